// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle signed non-restoring divider, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to short-circuit divide-by-zero and expose div_zero.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             div_zero
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
    state_t state, nxt;
    logic [WIDTH:0] a, m, sh, an, af;
    logic [WIDTH-1:0] qreg, absq, absm;
    logic [CW-1:0] count;
    logic sign_q, sign_r, skip;
    assign busy = state != IDLE;
    // In PREP, qreg and m still hold the raw operands latched on the accepting edge
    assign absq = qreg[WIDTH-1] ? -qreg : qreg;
    assign absm = m[WIDTH-1] ? -m[WIDTH-1:0] : m[WIDTH-1:0];
    assign sh = {a[WIDTH-1:0], qreg[WIDTH-1]};
    assign an = a[WIDTH] ? sh + m : sh - m;
    assign af = a[WIDTH] ? a + m : a;
`ifdef DIV_ZERO_DETECT_EN
    assign skip = m[WIDTH-1:0] == '0;
`else
    assign skip = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        if (state != IDLE && abort) nxt = IDLE;
        else if (state == IDLE && start) nxt = PREP;
        else if (state == PREP) nxt = skip ? FIX : ITER;
        else if (state == ITER && count == LAST) nxt = FIX;
        else if (state == FIX) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            m         <= '0;
            qreg      <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                qreg   <= dividend;
                m      <= {1'b0, divisor};
                sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                sign_r <= dividend[WIDTH-1];
                a      <= '0;
                count  <= '0;
`ifdef DIV_ZERO_DETECT_EN
                div_zero <= 1'b0;
`endif
            end else if (!abort) begin
                // A zero divisor jumps straight to FIX with the state the full loop would reach
                if (state == PREP) begin
                    a     <= skip ? {1'b0, absq} : '0;
                    qreg  <= skip ? '1 : absq;
                    m     <= {1'b0, absm};
                    count <= '0;
                end
                if (state == ITER) begin
                    a     <= an;
                    qreg  <= {qreg[WIDTH-2:0], ~an[WIDTH]};
                    count <= count + 1'b1;
                end
                if (state == FIX) begin
                    a         <= af;
                    quotient  <= sign_q ? -qreg : qreg;
                    remainder <= sign_r ? -af[WIDTH-1:0] : af[WIDTH-1:0];
                    done      <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero  <= skip;
`endif
                end
            end
        end
    end
endmodule
